fetch_predictor: RTL

//  Fetch-side PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating

---
 rtl/fetch_predictor_pkg.sv | 27 ++
 rtl/fetch_predictor_btb.sv | 68 ++++++
 rtl/fetch_predictor.sv | 71 +++++++
 3 files changed

// File: rtl/fetch_predictor_pkg.sv
// Shared constants and the 2-bit direction-counter helper for the fetch predictor.
package fetch_predictor_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam int BTB_CTR_BITS = 2;
    localparam int PC_STEP      = 4;

    typedef enum logic [BTB_CTR_BITS-1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } ctr_e;

    // Saturating step toward the resolved direction.
    function automatic ctr_e ctr_update(input ctr_e cur, input logic taken);
        ctr_e nxt;
        nxt = cur;
        if (taken) begin
            if (cur != CTR_STRONG_T) nxt = ctr_e'(cur + 2'd1);
        end else begin
            if (cur != CTR_STRONG_NT) nxt = ctr_e'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fetch_predictor_btb.sv
// Direct-mapped branch target buffer: async lookup, synchronous resolve-time update.
module fetch_predictor_btb
    import fetch_predictor_pkg::*;
#(
    parameter int XLEN    = DEFAULT_XLEN,
    parameter int ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] rd_pc_i,
    output logic            rd_hit_o,
    output ctr_e            rd_ctr_o,
    output logic [XLEN-1:0] rd_target_o,
    input  logic            wr_en_i,
    input  logic [XLEN-1:0] wr_pc_i,
    input  logic            wr_taken_i,
    input  logic [XLEN-1:0] wr_target_i
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    ctr_e               ctr_q    [ENTRIES];

    logic [IDX-1:0]   rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             wr_hit;
    logic             unused_lsbs;

    assign rd_idx = rd_pc_i[IDX+1:2];
    assign rd_tag = rd_pc_i[XLEN-1:IDX+2];
    assign wr_idx = wr_pc_i[IDX+1:2];
    assign wr_tag = wr_pc_i[XLEN-1:IDX+2];
    assign unused_lsbs = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

    // Lookup reads the registered contents, so a same-cycle write is not visible yet.
    assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_ctr_o    = ctr_q[rd_idx];
    assign rd_target_o = target_q[rd_idx];

    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WEAK_NT;
            end
        end else if (wr_en_i) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= ctr_update(ctr_q[wr_idx], wr_taken_i);
                if (wr_taken_i) target_q[wr_idx] <= wr_target_i;
            end else if (wr_taken_i) begin
                // Miss on a taken branch replaces whatever aliased into this slot.
                valid_q[wr_idx]  <= 1'b1;
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= wr_target_i;
                ctr_q[wr_idx]    <= CTR_WEAK_T;
            end
        end
    end

endmodule

// File: rtl/fetch_predictor.sv
// Fetch PC generator: BTB-predicted next PC with execute-stage mispredict redirect.
module fetch_predictor
    import fetch_predictor_pkg::*;
#(
    parameter int              XLEN        = DEFAULT_XLEN,
    parameter int              BTB_ENTRIES = 64,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_fetch_i,
    input  logic            ex_branch_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic            ex_taken_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            ex_pred_taken_i,
    input  logic [XLEN-1:0] ex_pred_target_i,
    output logic [XLEN-1:0] pc_fetch_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    output logic            flush_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] btb_target;
    logic            btb_hit;
    ctr_e            btb_ctr;
    logic            mispredict;

    fetch_predictor_btb #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_pc_i     (pc_q),
        .rd_hit_o    (btb_hit),
        .rd_ctr_o    (btb_ctr),
        .rd_target_o (btb_target),
        .wr_en_i     (ex_branch_i),
        .wr_pc_i     (ex_pc_i),
        .wr_taken_i  (ex_taken_i),
        .wr_target_i (ex_target_i)
    );

    assign pred_taken_o  = btb_hit && btb_ctr[1];
    assign pred_target_o = pred_taken_o ? btb_target : pc_q + XLEN'(PC_STEP);

    // A taken branch must also have gone to the predicted target to count as correct.
    assign mispredict = ex_branch_i &&
                        ((ex_taken_i != ex_pred_taken_i) ||
                         (ex_taken_i && (ex_target_i != ex_pred_target_i)));
    assign flush_o    = mispredict;

    always_comb begin
        pc_d = pred_target_o;
        if (mispredict) begin
            pc_d = ex_taken_i ? ex_target_i : ex_pc_i + XLEN'(PC_STEP);
        end else if (stall_fetch_i) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    assign pc_fetch_o = pc_q;

endmodule
